// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the decode hazard/stall unit: FSM encoding, widths and
// the single-source register-address comparator.
package hazard_stall_unit_pkg;

    localparam int REG_W      = 3;
    localparam int PIPE_DEPTH = 3;
    localparam int CNT_W      = 16;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } dest_t;

    // One source operand against one tracked destination; invalid entries never match.
    function automatic logic src_match(input logic             src_valid,
                                       input logic [REG_W-1:0] src,
                                       input dest_t            ent);
        return src_valid & ent.valid & (src == ent.rd);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_dest_pipe_reg.sv
// One stage of the destination-tracking pipeline: a resettable {valid, rd} register.
module dest_pipe_reg
    import hazard_stall_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  dest_t i_d,
    output dest_t o_q
);

    dest_t r_q;

    always_ff @(posedge clk) begin
        if (rst) r_q <= '0;
        else     r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard detector: tracks in-flight destinations (IDEX/EXMEM/MEMWB)
// and stalls decode until the youngest matching producer has left MEMWB.
//
// state | meaning
// RUN   | no hazard in progress, or a MEMWB-only hazard (single stall cycle)
// WAIT  | stalling on an older producer; stallCnt = stall cycles still to come
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             instrValid,
    input  logic [REG_W-1:0] rs,
    input  logic             rsValid,
    input  logic [REG_W-1:0] rt,
    input  logic             rtValid,
    input  logic [REG_W-1:0] rd,
    input  logic             rdWrite,
    input  logic             flush,
    output logic             stall,
    output logic [REG_W-1:0] rdIDEX,
    output logic [REG_W-1:0] rdEXMEM,
    output logic [REG_W-1:0] rdMEMWB,
    output logic             vIDEX,
    output logic             vEXMEM,
    output logic             vMEMWB,
    output logic [1:0]       stallCnt,
    output logic [CNT_W-1:0] stallTotal
);

    dest_t                 w_stage [PIPE_DEPTH];
    dest_t                 w_idex_d;
    dest_t                 w_exmem_d;
    logic [PIPE_DEPTH-1:0] w_match;
    logic                  w_stall;
    logic [1:0]            w_depth;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_cnt;
    logic [1:0]            w_cnt_nxt;
    logic [CNT_W-1:0]      r_stall_total;

    assign w_idex_d  = (instrValid & ~w_stall & ~flush) ? dest_t'{rdWrite, rd} : '0;
    assign w_exmem_d = flush ? '0 : w_stage[0];

    dest_pipe_reg u_idex  (.clk(clk), .rst(rst), .i_d(w_idex_d),   .o_q(w_stage[0]));
    dest_pipe_reg u_exmem (.clk(clk), .rst(rst), .i_d(w_exmem_d),  .o_q(w_stage[1]));
    dest_pipe_reg u_memwb (.clk(clk), .rst(rst), .i_d(w_stage[1]), .o_q(w_stage[2]));

    // Index 0 is the youngest stage; it sets the remaining-stall depth when several match.
    always_comb begin
        w_match = '0;
        w_depth = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            w_match[k] = src_match(rsValid, rs, w_stage[k]) | src_match(rtValid, rt, w_stage[k]);
            if (w_match[k]) w_depth = 2'(PIPE_DEPTH - 1 - k);
        end
    end

    assign w_stall = instrValid & ~flush & (|w_match);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
        if (w_stall) begin
            case (r_state)
                ST_RUN: begin
                    if (w_depth != 2'd0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = w_depth;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt > 2'd1) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = r_cnt - 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall    = w_stall;
        stallCnt = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst)                                   r_stall_total <= '0;
        else if (w_stall && (r_stall_total != '1)) r_stall_total <= r_stall_total + 1'b1;
    end

    assign stallTotal = r_stall_total;
    assign rdIDEX     = w_stage[0].rd;
    assign rdEXMEM    = w_stage[1].rd;
    assign rdMEMWB    = w_stage[2].rd;
    assign vIDEX      = w_stage[0].valid;
    assign vEXMEM     = w_stage[1].valid;
    assign vMEMWB     = w_stage[2].valid;

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state updates on the rising clk edge.
REQ-002 SHALL expose ports, clock and reset first (name  dir  width  meaning):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- instrValid  in  1  valid instruction in decode
- rs  in  3  decode source reg A
- rsValid  in  1  instruction reads rs
- rt  in  3  decode source reg B
- rtValid  in  1  instruction reads rt
- rd  in  3  decode destination reg
- rdWrite  in  1  instruction writes rd
- flush  in  1  squash decode and IDEX (taken branch/jump)
- stall  out  1  hold fetch/decode, bubble into IDEX
- rdIDEX, rdEXMEM, rdMEMWB  out  3 each  tracked destinations
- vIDEX, vEXMEM, vMEMWB  out  1 each  destination valid (will write)
- stallCnt  out  2  remaining stall cycles, current hazard
- stallTotal  out  16  saturating count of stall cycles

Function
REQ-003 SHALL keep a 3-entry destination pipeline {valid, rd[2:0]}: IDEX -> EXMEM -> MEMWB; outputs are the registered entries.
REQ-004 SHALL advance EXMEM<=IDEX and MEMWB<=EXMEM every cycle (back end never stalls).
REQ-005 SHALL load IDEX<={rdWrite, rd} when instrValid & !stall & !flush; otherwise load a bubble {0, 3'b000}.
REQ-006 SHALL compute match per stage X: (rsValid & vX & rs==rdX) | (rtValid & vX & rt==rdX); the register file has no write-before-read bypass, so a MEMWB match is a hazard.
REQ-007 SHALL drive stall = instrValid & !flush & (matchIDEX | matchEXMEM | matchMEMWB), combinationally, in the same cycle as decode.
REQ-008 SHALL ignore entries with valid=0 regardless of rd value; rd=0 is an ordinary register.
REQ-009 SHALL implement an FSM with states RUN and WAIT:
- RUN and stall: go to WAIT; load stallCnt = depth-1 of the youngest matching stage (IDEX=2, EXMEM=1, MEMWB=0).
- RUN and stall with depth-1 = 0 (MEMWB only): stay in RUN with stallCnt=0.
- WAIT: decrement stallCnt each cycle; return to RUN when stallCnt=1 and decrementing to 0.
- In RUN with no stall, stallCnt=0.
REQ-010 SHALL guarantee stall deasserts exactly in the first cycle after stallCnt reaches 0 for an unchanged decode instruction (self-consistency property).
REQ-011 SHALL, on flush, load bubbles into IDEX and EXMEM, set MEMWB<=EXMEM normally, force FSM to RUN and stallCnt=0; flush overrides stall.
REQ-012 SHALL increment stallTotal each cycle stall=1 and saturate at 16'hFFFF (no wrap).
REQ-013 SHALL treat instrValid=0 as no hazard: stall=0, IDEX loads a bubble, and the FSM returns to RUN.

Reset
REQ-014 SHALL, when rst=1 at a clock edge, clear all valid bits and rd fields to 0, set the FSM to RUN, stallCnt=0 and stallTotal=0; reset overrides flush and stall.
REQ-015 SHALL, with rst asserted mid-stall, drive stall=0 in the cycle after the reset edge unless the new decode inputs create a hazard.

Structure
REQ-016 SHALL place the FSM state encoding (RUN, WAIT), the register-index width (3), the pipeline depth (3) and the counter width (16) in the shared pipeline package.
REQ-017 SHALL reuse the existing 1-source address comparator once per source operand; the stage registers SHALL be a single sub-module, dest_pipe_reg, instantiated three times.

Verification
REQ-018 SHALL cover: write r3 at cycle 0, next cycle read rs=3 -> stall=1 for 3 cycles, stallCnt 2,1,0, IDEX bubble each cycle, stallTotal=3.
REQ-019 SHALL cover: write r5, one independent instruction, then read rt=5 -> stall=1 for 2 cycles; rsValid=0 with rs=5 -> stall=0.
REQ-020 SHALL cover: vIDEX=0 with rdIDEX=3 and rs=3 -> stall=0.
REQ-021 SHALL cover: flush asserted during WAIT with a producer in IDEX -> stall=0 that cycle; next cycle vIDEX=vEXMEM=0, FSM RUN, stallCnt=0.
REQ-022 SHALL cover: stallTotal preset near 16'hFFFE plus 3 stall cycles -> stallTotal holds at 16'hFFFF.
REQ-023 SHALL cover: rst asserted while stallCnt=1 -> all outputs zero next cycle, stallTotal=0.
